// File: rtl/update_unit_cd_batch.sv
// Mini-batch contrastive-divergence weight updater: accumulates per-channel CD deltas
// over a batch, then applies one scaled, saturated update to a streamed weight word.
module update_unit_cd_batch #(
    parameter int NUM_CH    = 16,
    parameter int BW_W      = 16,
    parameter int BATCH_MAX = 64,
    parameter int STEP_EXP  = 8,
    parameter int CNT_W     = $clog2(BATCH_MAX + 1),
    parameter int ACC_W     = $clog2(BATCH_MAX + 1) + 1,
    parameter int LR_W      = $clog2(STEP_EXP + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [CNT_W-1:0]       batch_size,
    input  logic [LR_W-1:0]        lr_shift,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NUM_CH-1:0]      v_pos,
    input  logic                   h_pos,
    input  logic [NUM_CH-1:0]      v_neg,
    input  logic                   h_neg,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [NUM_CH*BW_W-1:0] w_in,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [NUM_CH*BW_W-1:0] w_out,
    output logic [NUM_CH-1:0]      sat
);

    localparam int SUM_W = ((BW_W > ACC_W + STEP_EXP) ? BW_W : (ACC_W + STEP_EXP)) + 1;
    localparam logic signed [SUM_W-1:0] W_MAX = {{(SUM_W-BW_W+1){1'b0}}, {(BW_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] W_MIN = {{(SUM_W-BW_W+1){1'b1}}, {(BW_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_WAIT_W = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Clamp a wide sum into the weight range; MSB of the result flags a clip.
    function automatic logic [BW_W:0] sat_fn(input logic signed [SUM_W-1:0] v);
        logic [BW_W:0] r;
        if (v > W_MAX) begin
            r = {1'b1, W_MAX[BW_W-1:0]};
        end else if (v < W_MIN) begin
            r = {1'b1, W_MIN[BW_W-1:0]};
        end else begin
            r = {1'b0, v[BW_W-1:0]};
        end
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic                    s_ready_r;
    logic                    w_ready_r;
    logic                    o_valid_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        size_r;
    logic [CNT_W-1:0]        size_in_s;
    logic [CNT_W-1:0]        size_cur_s;
    logic [LR_W-1:0]         lr_r;
    logic [LR_W-1:0]         lr_in_s;
    logic [LR_W-1:0]         shamt_s;
    logic signed [ACC_W-1:0] acc_r    [NUM_CH];
    logic signed [ACC_W-1:0] acc_nx_s [NUM_CH];
    logic signed [SUM_W-1:0] w_ext_s  [NUM_CH];
    logic signed [SUM_W-1:0] a_ext_s  [NUM_CH];
    logic signed [SUM_W-1:0] sum_s    [NUM_CH];
    logic [BW_W:0]           clip_s   [NUM_CH];
    logic [NUM_CH*BW_W-1:0]  w_out_r;
    logic [NUM_CH*BW_W-1:0]  w_new_s;
    logic [NUM_CH-1:0]       sat_r;
    logic [NUM_CH-1:0]       sat_new_s;
    logic                    s_fire_s;
    logic                    w_fire_s;
    logic                    o_fire_s;
    logic                    last_s;

    // clr masks the ready lines in its own cycle so no handshake can complete alongside it.
    assign s_ready  = s_ready_r & ~clr;
    assign w_ready  = w_ready_r & ~clr;
    assign o_valid  = o_valid_r;
    assign w_out    = w_out_r;
    assign sat      = sat_r;
    assign s_fire_s = s_valid & s_ready;
    assign w_fire_s = w_valid & w_ready;
    assign o_fire_s = o_valid_r & o_ready & ~clr;

    // Batch-start parameter clamping and end-of-batch detection.
    always_comb begin
        if (batch_size == {CNT_W{1'b0}}) begin
            size_in_s = CNT_W'(1);
        end else if (batch_size > CNT_W'(BATCH_MAX)) begin
            size_in_s = CNT_W'(BATCH_MAX);
        end else begin
            size_in_s = batch_size;
        end
        if (lr_shift > LR_W'(STEP_EXP)) begin
            lr_in_s = LR_W'(STEP_EXP);
        end else begin
            lr_in_s = lr_shift;
        end
        if (cnt_r == {CNT_W{1'b0}}) begin
            size_cur_s = size_in_s;
        end else begin
            size_cur_s = size_r;
        end
        last_s  = s_fire_s && ((cnt_r + CNT_W'(1)) == size_cur_s);
        shamt_s = LR_W'(STEP_EXP) - lr_r;
    end

    // Per-channel CD delta accumulation and scaled, saturated weight update.
    always_comb begin
        w_new_s   = {(NUM_CH*BW_W){1'b0}};
        sat_new_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            acc_nx_s[c] = acc_r[c] + ACC_W'(v_pos[c] & h_pos) - ACC_W'(v_neg[c] & h_neg);
            w_ext_s[c]  = SUM_W'($signed(w_in[BW_W*c +: BW_W]));
            a_ext_s[c]  = SUM_W'(acc_r[c]);
            sum_s[c]    = w_ext_s[c] + (a_ext_s[c] <<< shamt_s);
            clip_s[c]   = sat_fn(sum_s[c]);
            w_new_s[BW_W*c +: BW_W] = clip_s[c][BW_W-1:0];
            sat_new_s[c] = clip_s[c][BW_W];
        end
    end

    // Next-state logic; clr overrides every handshake.
    always_comb begin
        state_nx_s = state_r;
        if (clr) begin
            state_nx_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM:  state_nx_s = last_s   ? ST_WAIT_W : ST_ACCUM;
                ST_WAIT_W: state_nx_s = w_fire_s ? ST_OUT    : ST_WAIT_W;
                ST_OUT:    state_nx_s = o_fire_s ? ST_ACCUM  : ST_OUT;
                default:   state_nx_s = ST_ACCUM;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready_r <= 1'b0;
            w_ready_r <= 1'b0;
            o_valid_r <= 1'b0;
        end else begin
            s_ready_r <= (state_nx_s == ST_ACCUM);
            w_ready_r <= (state_nx_s == ST_WAIT_W);
            o_valid_r <= (state_nx_s == ST_OUT);
        end
    end

    // Accumulators, batch counter, latched batch parameters and output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            size_r  <= {CNT_W{1'b0}};
            lr_r    <= {LR_W{1'b0}};
            w_out_r <= {(NUM_CH*BW_W){1'b0}};
            sat_r   <= {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= {ACC_W{1'b0}};
            end
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= {ACC_W{1'b0}};
            end
        end else begin
            if (s_fire_s) begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    size_r <= size_in_s;
                    lr_r   <= lr_in_s;
                end
                cnt_r <= cnt_r + CNT_W'(1);
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_r[c] <= acc_nx_s[c];
                end
            end else if (o_fire_s) begin
                cnt_r <= {CNT_W{1'b0}};
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_r[c] <= {ACC_W{1'b0}};
                end
            end
            if (w_fire_s) begin
                w_out_r <= w_new_s;
                sat_r   <= sat_new_s;
            end
        end
    end

endmodule
